// File: rtl/seg_bank_if.sv
// seg_bank_if: control/data bundle for seg_bank_driver.
//   enable     : 1 = block runs, 0 = state frozen and load ignored
//   load       : capture value into the digit registers this edge
//   value      : nibble i = value[4i+3:4i], new hex value for digit i
//   blink_mask : 1 = digit i blinks continuously
//   blank_mask : 1 = digit i forced dark
//   interx     : 1 = suppress blink darkness
//   hex        : digit i = hex[7i+6:7i], active-low segments, bit0 = a .. bit6 = g
//   phase      : blink phase, 0 = visible half, 1 = dark half
// master drives the controls (testbench / host), slave is the driver block.
interface seg_bank_if #(
    parameter int NDIG = 4
);
    logic                enable;
    logic                load;
    logic [4*NDIG-1:0]   value;
    logic [NDIG-1:0]     blink_mask;
    logic [NDIG-1:0]     blank_mask;
    logic                interx;
    logic [7*NDIG-1:0]   hex;
    logic                phase;

    modport master (
        output enable, load, value, blink_mask, blank_mask, interx,
        input  hex, phase
    );

    modport slave (
        input  enable, load, value, blink_mask, blank_mask, interx,
        output hex, phase
    );
endinterface

// File: rtl/seg_bank_driver.sv
// seg_bank_driver: bank of NDIG seven-segment digits with continuous blink,
// forced blanking, and an automatic flash after a digit's value changes.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears digits, flash counters, blink state
//   bus   : seg_bank_if slave modport (controls in, hex/phase out)
// Parameters:
//   NDIG       : digit count (1..8)
//   BLINK_DIV  : clock cycles per blink half-period (>= 2)
//   CHG_HALVES : half-periods a digit flashes after its value changes (>= 1)
module seg_bank_driver #(
    parameter int NDIG       = 4,
    parameter int BLINK_DIV  = 16,
    parameter int CHG_HALVES = 4
) (
    input  logic         clk,
    input  logic         reset,
    seg_bank_if.slave    bus
);
    localparam int CW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int CHW = $clog2(CHG_HALVES + 1);

    logic [CW-1:0]  cnt;
    logic           phase_q;
    logic [3:0]     digit [NDIG];
    logic [CHW-1:0] chg   [NDIG];
    logic           toggle;

    // Toggle edge: last count of the half-period while running.
    assign toggle = bus.enable && (cnt == CW'(BLINK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            phase_q <= 1'b0;
            for (int unsigned i = 0; i < NDIG; i++) begin
                digit[i] <= '0;
                chg[i]   <= '0;
            end
        end else if (bus.enable) begin
            if (toggle) begin
                cnt     <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt <= cnt + 1'b1;
            end
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (bus.load) begin
                    digit[i] <= bus.value[4*i +: 4];
                end
                // A changed nibble restarts the flash and wins over the
                // half-period decrement on the same edge.
                if (bus.load && (bus.value[4*i +: 4] != digit[i])) begin
                    chg[i] <= CHW'(CHG_HALVES);
                end else if (toggle && (chg[i] != '0)) begin
                    chg[i] <= chg[i] - 1'b1;
                end
            end
        end
    end

    function automatic logic [6:0] encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        bus.hex = '1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bus.blank_mask[i]) begin
                bus.hex[7*i +: 7] = '1;
            end else if (bus.interx) begin
                bus.hex[7*i +: 7] = encode(digit[i]);
            end else if ((bus.blink_mask[i] || (chg[i] != '0)) && phase_q) begin
                bus.hex[7*i +: 7] = '1;
            end else begin
                bus.hex[7*i +: 7] = encode(digit[i]);
            end
        end
    end

    assign bus.phase = phase_q;

endmodule

// File: doc/seg_bank_driver.md
SEG_BANK_DRIVER -- requirements
Module: seg_bank_driver

Interface
REQ-001 Parameter NDIG, default 4: number of seven-segment digits, range 1..8.
REQ-002 Parameter BLINK_DIV, default 16: clock cycles per blink half-period, at least 2.
REQ-003 Parameter CHG_HALVES, default 4: half-periods a digit auto-flashes after its value changes, at least 1.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  1 = block runs; 0 = all state frozen and load ignored.
REQ-007 load  in  1  1 = capture value into the digit registers this edge.
REQ-008 value  in  4*NDIG  nibble i = value[4i+3:4i], the new hex value for digit i.
REQ-009 blink_mask  in  NDIG  1 = digit i blinks continuously.
REQ-010 blank_mask  in  NDIG  1 = digit i is forced dark.
REQ-011 interx  in  1  1 = suppress all blink darkness, so blinking digits show steady.
REQ-012 hex  out  7*NDIG  digit i = hex[7i+6:7i], active-low segments, bit0 = a ... bit6 = g.
REQ-013 phase  out  1  current blink phase: 0 = visible half, 1 = dark half.

Function
REQ-014 Encoding, 0..F in order: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-015 Dark pattern: 1111111.
REQ-016 Blink counter runs 0..BLINK_DIV-1 while enable=1 and holds its value while enable=0.
REQ-017 On the edge where the counter equals BLINK_DIV-1, the counter wraps to 0 and phase toggles; this edge is the "toggle edge".
REQ-018 Load is accepted only when load=1 and enable=1 at an edge; every digit register takes its nibble at that edge.
REQ-019 Each digit has a change counter chg_i, width clog2(CHG_HALVES+1).
  - On an accepted load where nibble i differs from the stored value, chg_i is set to CHG_HALVES.
  - This reload also applies while chg_i is already nonzero, and takes priority over a decrement on the same edge.
REQ-020 At each toggle edge, every nonzero chg_i that is not being reloaded decrements by 1.
REQ-021 An accepted load with an unchanged nibble leaves chg_i untouched.
REQ-022 Digit i is "blinking" when blink_mask[i]=1 or chg_i != 0.
REQ-023 Digit i output, in priority order (first match wins):
  - blank_mask[i]=1 -> dark;
  - interx=1 -> encoded stored value;
  - blinking and phase=1 -> dark;
  - otherwise -> encoded stored value.
REQ-024 hex and phase are combinational from the registered state, blank_mask, blink_mask and interx.
  - A value loaded at edge k appears on hex immediately after edge k, with no extra register stage.
REQ-025 The blink, blank and interx inputs never alter the stored digit values or the counters.
REQ-026 With enable=0, hex still follows the mask and interx inputs against the frozen phase.

Reset
REQ-027 When reset=1 at an edge, the block SHALL clear all state:
  - digit registers = 0; chg_i = 0;
  - blink counter = 0; phase = 0.
REQ-028 Reset takes priority over enable and load.
REQ-029 The first edge after reset deasserts is counter step 0->1.
REQ-030 After reset with masks=0, every hex digit SHALL read 1000000.
REQ-031 Reset mid-flash SHALL immediately cancel all pending change flashes.

Verification
REQ-032 The bench SHALL use NDIG=4, BLINK_DIV=4, CHG_HALVES=2 and cover the following scenarios.
REQ-033 Reset, then 3 idle cycles, masks 0 -> hex = {4{1000000}}, phase=0; phase becomes 1 after edge 4 and 0 after edge 8.
REQ-034 Load value=16'h00A0 at edge k -> digit1 shows 0001000 and flashes:
  - it is dark during the next phase=1 half;
  - it is steady after 2 toggle edges;
  - digits 0, 2 and 3 never go dark.
REQ-035 blink_mask=4'b0001, interx pulsed for 3 cycles during phase=1 -> digit0 shows 1000000 while interx=1 and 1111111 once interx returns to 0 with phase still 1.
REQ-036 blank_mask=4'b1000 with interx=1 -> digit3 = 1111111 throughout.
REQ-037 enable=0 with load=1 and value=16'hFFFF for 6 cycles -> hex, phase and the counter are unchanged.
REQ-038 Load a new digit2 value during its change flash -> chg_2 reloads to 2.
REQ-039 Assert reset during a change flash -> all digits show 1000000 and no flash follows.
